// File: rtl/wb_stream_bridge.sv
// Wishbone classic slave bridging CTRL/DATA/STAT/LEVEL registers to a TX and an RX byte stream,
// each buffered by a small FIFO. Assumes WB_DATA_WIDTH >= 8 and FIFO_DEPTH a power of two.
module wb_stream_bridge #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     irq_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [WB_DATA_WIDTH-1:0] tx_data_o,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  input  logic [WB_DATA_WIDTH-1:0] rx_data_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ADR_CTRL  = 2'd0;
  localparam logic [1:0] ADR_DATA  = 2'd1;
  localparam logic [1:0] ADR_STAT  = 2'd2;
  localparam logic [1:0] ADR_LEVEL = 2'd3;

  logic                     ack_reg, irq_reg, en_reg, irq_en_reg, tx_ovf_reg, rx_udf_reg;
  logic                     irq_next, en_next, irq_en_next, tx_ovf_next, rx_udf_next;
  logic [WB_DATA_WIDTH-1:0] dat_reg, dat_next;
  logic [PW-1:0]            tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [PW-1:0]            tx_wr_ptr_next, tx_rd_ptr_next, rx_wr_ptr_next, rx_rd_ptr_next;
  logic [CW-1:0]            tx_count_reg, rx_count_reg, tx_count_next, rx_count_next;

  logic [WB_DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [WB_DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];

  logic       bus_req, wr_req, rd_req, sel_data;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       flush, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] rdata;

  // A request only counts on the cycle that will raise ack; all side effects key off it.
  assign bus_req  = cyc_i & stb_i & ~ack_reg;
  assign wr_req   = bus_req & we_i;
  assign rd_req   = bus_req & ~we_i;
  assign sel_data = (adr_i[1:0] == ADR_DATA);

  assign tx_full  = (tx_count_reg == DEPTH_C);
  assign tx_empty = (tx_count_reg == '0);
  assign rx_full  = (rx_count_reg == DEPTH_C);
  assign rx_empty = (rx_count_reg == '0);

  assign flush   = wr_req & (adr_i[1:0] == ADR_CTRL) & dat_i[5];
  assign tx_push = wr_req & sel_data & ~tx_full;
  assign tx_pop  = tx_valid_o & tx_ready_i & ~flush;
  assign rx_push = rx_valid_i & rx_ready_o & ~flush;
  assign rx_pop  = rd_req & sel_data & ~rx_empty;

  assign tx_valid_o = en_reg & ~tx_empty;
  assign rx_ready_o = en_reg & ~rx_full;
  assign tx_data_o  = tx_mem[tx_rd_ptr_reg];
  assign ack_o      = ack_reg;
  assign dat_o      = dat_reg;
  assign irq_o      = irq_reg;

  always_comb begin
    en_next     = en_reg;
    irq_en_next = irq_en_reg;
    tx_ovf_next = tx_ovf_reg;
    rx_udf_next = rx_udf_reg;
    if (wr_req && adr_i[1:0] == ADR_CTRL) begin
      en_next     = dat_i[7];
      irq_en_next = dat_i[6];
    end
    if (wr_req && sel_data && tx_full) tx_ovf_next = 1'b1;
    if (rd_req && sel_data && rx_empty) rx_udf_next = 1'b1;
    if (wr_req && adr_i[1:0] == ADR_LEVEL) begin
      if (dat_i[3]) tx_ovf_next = 1'b0;
      if (dat_i[2]) rx_udf_next = 1'b0;
    end

    tx_wr_ptr_next = flush ? '0 : tx_wr_ptr_reg + PW'(tx_push);
    tx_rd_ptr_next = flush ? '0 : tx_rd_ptr_reg + PW'(tx_pop);
    tx_count_next  = flush ? '0 : tx_count_reg + CW'(tx_push) - CW'(tx_pop);
    rx_wr_ptr_next = flush ? '0 : rx_wr_ptr_reg + PW'(rx_push);
    rx_rd_ptr_next = flush ? '0 : rx_rd_ptr_reg + PW'(rx_pop);
    rx_count_next  = flush ? '0 : rx_count_reg + CW'(rx_push) - CW'(rx_pop);

    rdata = 8'h00;
    case (adr_i[1:0])
      ADR_CTRL:  rdata = {en_reg, irq_en_reg, 6'b0};
      ADR_DATA:  rdata = rx_empty ? 8'h00 : 8'(rx_mem[rx_rd_ptr_reg]);
      ADR_STAT:  rdata = {tx_full, tx_empty, rx_full, rx_empty, tx_ovf_reg, rx_udf_reg, 1'b0, irq_reg};
      default:   rdata = {4'(tx_count_reg), 4'(rx_count_reg)};
    endcase
    dat_next = rd_req ? WB_DATA_WIDTH'(rdata) : '0;

    // Computed from registered causes, so irq trails a cause change by one cycle.
    irq_next = irq_en_reg & (~rx_empty | tx_ovf_reg | rx_udf_reg);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
      irq_reg       <= 1'b0;
      en_reg        <= 1'b0;
      irq_en_reg    <= 1'b0;
      tx_ovf_reg    <= 1'b0;
      rx_udf_reg    <= 1'b0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      ack_reg       <= bus_req;
      dat_reg       <= dat_next;
      irq_reg       <= irq_next;
      en_reg        <= en_next;
      irq_en_reg    <= irq_en_next;
      tx_ovf_reg    <= tx_ovf_next;
      rx_udf_reg    <= rx_udf_next;
      tx_wr_ptr_reg <= tx_wr_ptr_next;
      tx_rd_ptr_reg <= tx_rd_ptr_next;
      tx_count_reg  <= tx_count_next;
      rx_wr_ptr_reg <= rx_wr_ptr_next;
      rx_rd_ptr_reg <= rx_rd_ptr_next;
      rx_count_reg  <= rx_count_next;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers and counts alone.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= dat_i;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data_i;
  end

endmodule

// File: tb/tb_wb_stream_bridge.sv
// Scoreboard bench for wb_stream_bridge: bus reads and TX stream bytes are checked by monitors
// against expectations queued when the stimulus is issued.
module tb_wb_stream_bridge;

  logic       clk = 1'b0;
  logic       rst, cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_w, dat_o, tx_data, rx_data;
  logic       ack_o, irq_o, tx_valid, tx_ready, rx_valid, rx_ready;

  int vectors = 0;
  int miscompares = 0;

  bit         sb_rd [$];
  logic [7:0] sb_val [$];
  string      sb_name [$];
  logic [7:0] tx_exp [$];

  bit         mon_rd;
  logic [7:0] mon_val;
  string      mon_name;

  wb_stream_bridge #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat_w), .ack_o(ack_o), .dat_o(dat_o), .irq_o(irq_o),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] exp, input string name);
    int n;
    sb_rd.push_back(!w);
    sb_val.push_back(exp);
    sb_name.push_back(name);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 20);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!ack_o) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: ack timeout, got ack=0, expected ack=1", name);
      void'(sb_rd.pop_back());
      void'(sb_val.pop_back());
      void'(sb_name.pop_back());
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    bus(1'b0, a, 8'h00, exp, name);
  endtask

  task automatic rx_send(input logic [7:0] d);
    int n;
    rx_valid = 1'b1;
    rx_data = d;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_send: rx_ready timeout, got 0, expected 1");
    end
    tick();
    rx_valid = 1'b0;
  endtask

  // Monitors: bus responses and TX stream beats, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && ack_o) begin
      if (sb_rd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_ack: got unexpected ack, expected none");
      end else begin
        mon_rd = sb_rd.pop_front();
        mon_val = sb_val.pop_front();
        mon_name = sb_name.pop_front();
        if (mon_rd) check(mon_name, dat_o, mon_val);
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_data: got unexpected byte 0x%0h, expected none", tx_data);
      end else begin
        check("tx_data", tx_data, tx_exp.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    check("reset_outputs", {ack_o, dat_o, irq_o, tx_valid, rx_ready}, 12'h000);
    rst = 1'b0;
    tick();

    // Build up irq and a TX entry, then reset in the middle of a DATA write.
    wr(2'd0, 8'hC0);
    rx_send(8'h5A);
    tick(); tick();
    check("irq_before_reset", irq_o, 1'b1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; dat_w = 8'h77;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 20);
    check("midwrite_ack_seen", ack_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {ack_o, irq_o, tx_valid, rx_ready}, 4'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rd(2'd2, 8'h50, "stat_after_reset");
    rd(2'd3, 8'h00, "level_after_reset");
    rd(2'd0, 8'h00, "ctrl_after_reset");

    // Basic TX path.
    wr(2'd0, 8'h80);
    tx_exp.push_back(8'hA5);
    wr(2'd1, 8'hA5);
    tx_exp.push_back(8'h3C);
    wr(2'd1, 8'h3C);
    rd(2'd3, 8'h20, "level_tx2");
    check("tx_valid_held", tx_valid, 1'b1);
    tx_ready = 1'b1;
    tick();
    check("tx_second_head", {tx_valid, tx_data}, {1'b1, 8'h3C});
    tick();
    check("tx_valid_drained", tx_valid, 1'b0);

    // TX overflow with the stream stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp.push_back(8'(8'h10 + i));
      wr(2'd1, 8'(8'h10 + i));
    end
    rd(2'd2, 8'h98, "stat_tx_ovf");
    rd(2'd3, 8'h80, "level_tx_full");
    wr(2'd3, 8'h08);
    rd(2'd2, 8'h90, "stat_ovf_cleared");
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("tx_drain_count", tx_exp.size(), 0);

    // RX path with interrupts and underflow.
    wr(2'd0, 8'hC0);
    rx_send(8'h11);
    rx_send(8'h22);
    tick(); tick();
    check("irq_rx_pending", irq_o, 1'b1);
    rd(2'd3, 8'h02, "level_rx2");
    rd(2'd1, 8'h11, "rx_pop0");
    rd(2'd1, 8'h22, "rx_pop1");
    tick(); tick();
    check("irq_rx_empty", irq_o, 1'b0);
    rd(2'd1, 8'h00, "rx_underflow_data");
    rd(2'd2, 8'h55, "stat_rx_udf");
    check("irq_rx_udf", irq_o, 1'b1);
    wr(2'd3, 8'h04);
    tick(); tick();
    check("irq_udf_cleared", irq_o, 1'b0);

    // Back-to-back DATA writes with the TX sink always ready.
    for (int i = 0; i < 6; i++) begin
      tx_exp.push_back(8'(8'h40 + i));
      wr(2'd1, 8'(8'h40 + i));
    end
    tick(); tick();
    check("tx_stream_all_seen", tx_exp.size(), 0);
    rd(2'd2, 8'h50, "stat_no_ovf");
    rd(2'd3, 8'h00, "level_tx_idle");

    // Fill RX, then flush.
    wr(2'd0, 8'h80);
    for (int i = 0; i < 8; i++) rx_send(8'(8'h80 + i));
    check("rx_ready_full", rx_ready, 1'b0);
    rd(2'd3, 8'h08, "level_rx_full");
    wr(2'd0, 8'hA0);
    check("rx_ready_after_flush", rx_ready, 1'b1);
    rd(2'd3, 8'h00, "level_after_flush");
    rd(2'd0, 8'h80, "ctrl_after_flush");

    tick(); tick();
    check("scoreboard_empty", sb_rd.size() + tx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
